// File: rtl/sdram_burst_traffic_gen.sv
// Burst write / read-back traffic generator for the SDRAM controller app port.
// Writes NUM_BURSTS patterned bursts, reads them back and tallies mismatches.
module sdram_burst_traffic_gen #(
    parameter int          APP_ADDR_WIDTH  = 24,
    parameter int          APP_BURST_WIDTH = 10,
    parameter int          SDR_DQ_WIDTH    = 16,
    parameter int          BURST_LEN       = 4,
    parameter int          NUM_BURSTS      = 16,
    parameter int unsigned START_ADDR      = 0,
    parameter int unsigned ADDR_STRIDE     = 4,
    parameter int          PATTERN_MODE    = 0,
    parameter int unsigned SEED            = 32'h0000_A5C3,
    parameter int          LOOP_EN         = 0,
    parameter int          TIMEOUT         = 4096
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic                       wr_burst_req,
    output logic [APP_BURST_WIDTH-1:0] wr_burst_len,
    output logic [APP_ADDR_WIDTH-1:0]  wr_burst_addr,
    output logic [SDR_DQ_WIDTH-1:0]    wr_burst_data,
    input  logic                       wr_burst_data_req,
    input  logic                       wr_burst_finish,
    output logic                       rd_burst_req,
    output logic [APP_BURST_WIDTH-1:0] rd_burst_len,
    output logic [APP_ADDR_WIDTH-1:0]  rd_burst_addr,
    input  logic [SDR_DQ_WIDTH-1:0]    rd_burst_data,
    input  logic                       rd_burst_data_valid,
    input  logic                       rd_burst_finish,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic                       timeout,
    output logic [15:0]                err_cnt,
    output logic [APP_ADDR_WIDTH-1:0]  first_err_addr,
    output logic [15:0]                loop_cnt
);

    localparam int AW  = APP_ADDR_WIDTH;
    localparam int DW  = SDR_DQ_WIDTH;
    localparam int CW  = APP_BURST_WIDTH + 1;
    localparam int BIW = $clog2(NUM_BURSTS + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam logic [AW-1:0] LP_START  = AW'(START_ADDR);
    localparam logic [AW-1:0] LP_STRIDE = AW'(ADDR_STRIDE);
    localparam logic [CW-1:0] LP_BL     = CW'(BURST_LEN);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_REQ, S_WR_WAIT, S_RD_REQ, S_RD_WAIT, S_CHECK, S_DONE
    } state_t;

    function automatic logic [DW-1:0] f_pat(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        case (PATTERN_MODE)
            1:       v = ~DW'(a);
            2:       v = DW'(1) << (a % AW'(DW));
            3:       v = DW'(a) ^ DW'(SEED);
            default: v = DW'(a);
        endcase
        return v;
    endfunction

    state_t         r_state;
    logic           r_start_d;
    logic           r_wr_req;
    logic           r_rd_req;
    logic           r_done;
    logic           r_timeout;
    logic [AW-1:0]  r_wr_addr;
    logic [AW-1:0]  r_rd_addr;
    logic [AW-1:0]  r_first_err;
    logic [DW-1:0]  r_wr_data;
    logic [CW-1:0]  r_wbeat;
    logic [CW-1:0]  r_rbeat;
    logic [BIW-1:0] r_bidx;
    logic [TW-1:0]  r_wdog;
    logic [15:0]    r_err;
    logic [15:0]    r_loop;

    logic           w_start_rise;
    logic           w_in_wr;
    logic           w_in_rd;
    logic           w_evt;
    logic           w_last;
    logic           w_wd_fire;
    logic           w_wr_err;
    logic           w_beat_err;
    logic           w_cnt_err;
    logic [AW-1:0]  w_rd_word;
    logic [CW-1:0]  w_rbeat_nx;
    logic [1:0]     w_err_inc;
    logic [16:0]    w_err_sum;
    logic [15:0]    w_err_nx;
    logic [AW-1:0]  w_err_addr;

    assign w_start_rise = start & ~r_start_d;
    assign w_in_wr      = (r_state == S_WR_WAIT);
    assign w_in_rd      = (r_state == S_RD_WAIT);
    assign w_evt        = (w_in_wr & (wr_burst_data_req | wr_burst_finish))
                        | (w_in_rd & (rd_burst_data_valid | rd_burst_finish));
    assign w_last       = (r_bidx == BIW'(NUM_BURSTS - 1));
    assign w_wd_fire    = (w_in_wr | w_in_rd) & ~w_evt
                        & (r_wdog == TW'(TIMEOUT - 1));

    assign w_wr_err   = w_in_wr & wr_burst_data_req & (r_wbeat >= LP_BL);
    assign w_rd_word  = r_rd_addr + AW'(r_rbeat);
    assign w_beat_err = w_in_rd & rd_burst_data_valid
                      & ((r_rbeat >= LP_BL) | (rd_burst_data != f_pat(w_rd_word)));
    // Beat count saturates one past the burst so overruns never wrap to a "good" count.
    assign w_rbeat_nx = (w_in_rd & rd_burst_data_valid & (r_rbeat <= LP_BL))
                      ? r_rbeat + CW'(1) : r_rbeat;
    assign w_cnt_err  = w_in_rd & rd_burst_finish & (w_rbeat_nx != LP_BL);
    assign w_err_inc  = {1'b0, w_wr_err | w_beat_err} + {1'b0, w_cnt_err};
    assign w_err_sum  = {1'b0, r_err} + 17'(w_err_inc);
    assign w_err_nx   = w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
    assign w_err_addr = w_wr_err   ? r_wr_addr + AW'(r_wbeat)
                      : w_beat_err ? w_rd_word
                      : r_rd_addr + AW'(w_rbeat_nx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_start_d   <= 1'b0;
            r_wr_req    <= 1'b0;
            r_rd_req    <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_wr_addr   <= '0;
            r_rd_addr   <= '0;
            r_first_err <= '0;
            r_wr_data   <= '0;
            r_wbeat     <= '0;
            r_rbeat     <= '0;
            r_bidx      <= '0;
            r_wdog      <= '0;
            r_err       <= '0;
            r_loop      <= '0;
        end else begin
            r_start_d <= start;
            if (w_err_inc != 2'd0) begin
                r_err <= w_err_nx;
                if (r_err == 16'd0) r_first_err <= w_err_addr;
            end
            if (w_evt) r_wdog <= '0;
            else if (w_in_wr | w_in_rd) r_wdog <= r_wdog + TW'(1);
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_rise) begin
                        r_err       <= '0;
                        r_first_err <= '0;
                        r_timeout   <= 1'b0;
                        r_done      <= 1'b0;
                        r_loop      <= '0;
                        r_bidx      <= '0;
                        r_wr_addr   <= LP_START;
                        r_state     <= S_WR_REQ;
                    end
                end
                S_WR_REQ: begin
                    r_wr_req  <= 1'b1;
                    r_wbeat   <= '0;
                    r_wr_data <= f_pat(r_wr_addr);
                    r_wdog    <= '0;
                    r_state   <= S_WR_WAIT;
                end
                S_WR_WAIT: begin
                    if (wr_burst_data_req && r_wbeat < LP_BL) begin
                        r_wbeat <= r_wbeat + CW'(1);
                        if (r_wbeat < LP_BL - CW'(1))
                            r_wr_data <= f_pat(r_wr_addr + AW'(r_wbeat) + AW'(1));
                    end
                    if (wr_burst_finish) begin
                        r_wr_req <= 1'b0;
                        if (w_last) begin
                            r_bidx    <= '0;
                            r_rd_addr <= LP_START;
                            r_state   <= S_RD_REQ;
                        end else begin
                            r_bidx    <= r_bidx + BIW'(1);
                            r_wr_addr <= r_wr_addr + LP_STRIDE;
                            r_state   <= S_WR_REQ;
                        end
                    end else if (w_wd_fire) begin
                        r_wr_req  <= 1'b0;
                        r_timeout <= 1'b1;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_RD_REQ: begin
                    r_rd_req <= 1'b1;
                    r_rbeat  <= '0;
                    r_wdog   <= '0;
                    r_state  <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    r_rbeat <= w_rbeat_nx;
                    if (rd_burst_finish) begin
                        r_rd_req <= 1'b0;
                        if (w_last) begin
                            r_state <= S_CHECK;
                        end else begin
                            r_bidx    <= r_bidx + BIW'(1);
                            r_rd_addr <= r_rd_addr + LP_STRIDE;
                            r_state   <= S_RD_REQ;
                        end
                    end else if (w_wd_fire) begin
                        r_rd_req  <= 1'b0;
                        r_timeout <= 1'b1;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_CHECK: begin
                    r_loop <= r_loop + 16'd1;
                    if ((LOOP_EN != 0) && start) begin
                        r_bidx    <= '0;
                        r_wr_addr <= LP_START;
                        r_state   <= S_WR_REQ;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign wr_burst_req   = r_wr_req;
    assign wr_burst_len   = APP_BURST_WIDTH'(BURST_LEN);
    assign wr_burst_addr  = r_wr_addr;
    assign wr_burst_data  = r_wr_data;
    assign rd_burst_req   = r_rd_req;
    assign rd_burst_len   = APP_BURST_WIDTH'(BURST_LEN);
    assign rd_burst_addr  = r_rd_addr;
    assign busy           = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done           = r_done;
    assign pass           = r_done && (r_err == 16'd0) && !r_timeout;
    assign timeout        = r_timeout;
    assign err_cnt        = r_err;
    assign first_err_addr = r_first_err;
    assign loop_cnt       = r_loop;

endmodule

// File: tb/tb_sdram_burst_traffic_gen.sv
// Bench for sdram_burst_traffic_gen: randomized-latency SDRAM responder plus
// an address/pattern reference model; two DUT configurations.
module tb_sdram_burst_traffic_gen;

    localparam int BL = 4;
    localparam int TO = 4096;

    logic clk;
    logic rst_n;
    logic [1:0] start, wreq, wdreq, wfin, rreq, rvld, rfin;
    logic [1:0] busy, done, pass, tmo;
    logic [1:0][9:0]  wlen, rlen;
    logic [1:0][23:0] waddr, raddr, fea;
    logic [1:0][15:0] wdata, rdata, errc, loopc;

    int n_tests;
    int n_fail;
    int ovl = 0;
    int cur;
    int flip_a;
    int short_a;
    bit no_rfin;
    bit rbusy;
    int wlog[$];
    int rlog[$];
    logic [15:0] mem [int];

    sdram_burst_traffic_gen u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]),
        .wr_burst_req(wreq[0]), .wr_burst_len(wlen[0]),
        .wr_burst_addr(waddr[0]), .wr_burst_data(wdata[0]),
        .wr_burst_data_req(wdreq[0]), .wr_burst_finish(wfin[0]),
        .rd_burst_req(rreq[0]), .rd_burst_len(rlen[0]),
        .rd_burst_addr(raddr[0]), .rd_burst_data(rdata[0]),
        .rd_burst_data_valid(rvld[0]), .rd_burst_finish(rfin[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .timeout(tmo[0]), .err_cnt(errc[0]),
        .first_err_addr(fea[0]), .loop_cnt(loopc[0])
    );

    sdram_burst_traffic_gen #(
        .START_ADDR(32'h00FF_FFF8), .NUM_BURSTS(4),
        .PATTERN_MODE(2), .LOOP_EN(1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]),
        .wr_burst_req(wreq[1]), .wr_burst_len(wlen[1]),
        .wr_burst_addr(waddr[1]), .wr_burst_data(wdata[1]),
        .wr_burst_data_req(wdreq[1]), .wr_burst_finish(wfin[1]),
        .rd_burst_req(rreq[1]), .rd_burst_len(rlen[1]),
        .rd_burst_addr(raddr[1]), .rd_burst_data(rdata[1]),
        .rd_burst_data_valid(rvld[1]), .rd_burst_finish(rfin[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .timeout(tmo[1]), .err_cnt(errc[1]),
        .first_err_addr(fea[1]), .loop_cnt(loopc[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk)
        if ((wreq[0] & rreq[0]) | (wreq[1] & rreq[1])) ovl++;

    function automatic int pat(input int mode, input int a);
        case (mode)
            1:       return ~a & 'hFFFF;
            2:       return 1 << (a % 16);
            3:       return (a ^ 'hA5C3) & 'hFFFF;
            default: return a & 'hFFFF;
        endcase
    endfunction

    function automatic int baddr(input int s, input int n);
        return (s + n * 4) & 'hFFFFFF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input int k);
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int budget, output int cyc);
        cyc = 0;
        while (done[k] !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_within_budget", done[k], 1);
    endtask

    task automatic wait_idle();
        int c = 0;
        while (rbusy && c < 500) begin
            @(negedge clk);
            c++;
        end
        @(negedge clk);
    endtask

    task automatic chk_addrs(input string tag, input int s, input int nb,
                             input int w0, input int r0);
        chk({tag, "_nwr"}, wlog.size() - w0, nb);
        chk({tag, "_nrd"}, rlog.size() - r0, nb);
        for (int n = 0; n < nb; n++) begin
            chk({tag, "_waddr"}, (w0 + n < wlog.size()) ? wlog[w0 + n] : -1,
                baddr(s, n));
            chk({tag, "_raddr"}, (r0 + n < rlog.size()) ? rlog[r0 + n] : -1,
                baddr(s, n));
        end
    endtask

    // Responder: serves the currently selected DUT with random latencies.
    initial begin : responder
        int k, a, n, w;
        logic [15:0] d;
        bit fin_done;
        wdreq = '0; wfin = '0; rvld = '0; rfin = '0; rdata = '0;
        rbusy = 1'b0;
        forever begin
            @(negedge clk);
            k = cur;
            if (rst_n && wreq[k]) begin
                rbusy = 1'b1;
                a = int'(waddr[k]);
                wlog.push_back(a);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                for (int b = 0; b < BL; b++) begin
                    repeat ($urandom_range(0, 1)) @(negedge clk);
                    wdreq[k] = 1'b1;
                    mem[(a + b) & 'hFFFFFF] = wdata[k];
                    @(negedge clk);
                    wdreq[k] = 1'b0;
                end
                wfin[k] = 1'b1;
                @(negedge clk);
                wfin[k] = 1'b0;
                rbusy = 1'b0;
            end else if (rst_n && rreq[k]) begin
                rbusy = 1'b1;
                a = int'(raddr[k]);
                rlog.push_back(a);
                n = (a == short_a) ? BL - 1 : BL;
                fin_done = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
                for (int b = 0; b < n; b++) begin
                    repeat ($urandom_range(0, 1)) @(negedge clk);
                    w = (a + b) & 'hFFFFFF;
                    d = mem.exists(w) ? mem[w] : 16'hDEAD;
                    if (w == flip_a) d = d ^ 16'h0001;
                    rdata[k] = d;
                    rvld[k] = 1'b1;
                    if (b == n - 1 && !no_rfin && $urandom_range(0, 1) == 1) begin
                        rfin[k] = 1'b1;
                        fin_done = 1'b1;
                    end
                    @(negedge clk);
                    rvld[k] = 1'b0;
                    rfin[k] = 1'b0;
                end
                if (no_rfin) begin
                    while (rreq[k]) @(negedge clk);
                end else if (!fin_done) begin
                    rfin[k] = 1'b1;
                    @(negedge clk);
                    rfin[k] = 1'b0;
                end
                rbusy = 1'b0;
            end
        end
    end

    initial begin : main
        int cyc, w0, r0, c;
        n_tests = 0; n_fail = 0;
        rst_n = 1'b0; start = '0; cur = 0;
        flip_a = -1; short_a = -1; no_rfin = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wreq", wreq, 0);
        chk("rst_rreq", rreq, 0);
        chk("rst_wlen", wlen[0], BL);
        chk("rst_rlen", rlen[1], BL);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_tmo", tmo, 0);
        chk("rst_err", errc[0], 0);
        chk("rst_loop", loopc[0], 0);
        chk("rst_waddr", waddr[1], 0);
        chk("rst_wdata", wdata[0], 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Ideal run, plus a start pulse while busy that must be ignored
        w0 = wlog.size(); r0 = rlog.size();
        pulse(0);
        repeat (20) @(negedge clk);
        chk("t1_busy", busy[0], 1);
        pulse(0);
        wait_done(0, 5000, cyc);
        chk("t1_pass", pass[0], 1);
        chk("t1_err", errc[0], 0);
        chk("t1_loop", loopc[0], 1);
        chk("t1_tmo", tmo[0], 0);
        chk("t1_busy_end", busy[0], 0);
        chk_addrs("t1", 0, 16, w0, r0);
        for (int a = 0; a < 64; a++)
            chk("t1_mem", mem.exists(a) ? int'(mem[a]) : -1, pat(0, a));
        wait_idle();

        // Single corrupted read word
        flip_a = 'h09;
        pulse(0);
        wait_done(0, 5000, cyc);
        chk("t2_err", errc[0], 1);
        chk("t2_first", fea[0], 'h09);
        chk("t2_pass", pass[0], 0);
        flip_a = -1;
        wait_idle();

        // Missing read finish -> watchdog
        no_rfin = 1'b1;
        pulse(0);
        wait_done(0, 8000, cyc);
        chk("t3_tmo", tmo[0], 1);
        chk("t3_rreq", rreq[0], 0);
        chk("t3_pass", pass[0], 0);
        chk("t3_busy", busy[0], 0);
        chk("t3_long", cyc >= TO, 1);
        no_rfin = 1'b0;
        wait_idle();

        // Short read burst at word 8
        short_a = 8;
        pulse(0);
        wait_done(0, 5000, cyc);
        chk("t5_err", errc[0], 1);
        chk("t5_pass", pass[0], 0);
        chk("t5_tmo", tmo[0], 0);
        short_a = -1;
        wait_idle();

        // Reset asserted mid write burst
        pulse(0);
        c = 0;
        while (!(wreq[0] && wdreq[0]) && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("t5_dreq_seen", wreq[0] & wdreq[0], 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_wreq", wreq[0], 0);
        chk("t5_rst_busy", busy[0], 0);
        chk("t5_rst_done", done[0], 0);
        wait_idle();
        rst_n = 1'b1;
        @(negedge clk);

        // Address wrap, walking-one pattern
        cur = 1;
        w0 = wlog.size(); r0 = rlog.size();
        pulse(1);
        wait_done(1, 3000, cyc);
        chk("t4_pass", pass[1], 1);
        chk("t4_err", errc[1], 0);
        chk("t4_loop", loopc[1], 1);
        chk_addrs("t4", 'hFFFFF8, 4, w0, r0);
        for (int n = 0; n < 16; n++) begin
            int a = ('hFFFFF8 + n) & 'hFFFFFF;
            chk("t4_mem", mem.exists(a) ? int'(mem[a]) : -1, pat(2, a));
        end
        wait_idle();

        // Looping while start is held
        w0 = wlog.size(); r0 = rlog.size();
        start[1] = 1'b1;
        @(negedge clk);
        c = 0;
        while (loopc[1] !== 16'd2 && c < 3000) begin
            @(negedge clk);
            c++;
        end
        chk("t6_loop2", loopc[1], 2);
        start[1] = 1'b0;
        wait_done(1, 3000, cyc);
        chk("t6_loop", loopc[1], 3);
        chk("t6_pass", pass[1], 1);
        chk("t6_err", errc[1], 0);
        chk("t6_nwr", wlog.size() - w0, 12);
        chk("t6_nrd", rlog.size() - r0, 12);
        chk("no_overlap", ovl, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
